// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit and its data_memory port.
package load_store_unit_pkg;

    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_WR,
        RMW_REQ,
        RMW_WAIT,
        RMW_WR,
        RESP
    } lsu_state_t;

    typedef enum logic {
        MEM_READ_EN  = 1'b0,
        MEM_WRITE_EN = 1'b1
    } mem_en_t;

    typedef struct packed {
        logic    mem_enable;
        mem_en_t mem_en;
        word     address;
        word     data_in;
    } data_memory_interface_t;

    // Size code 3 is unused and treated like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'd3)
            || ((size == SIZE_H) && addr_lo[0])
            || ((size == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  word        load_word,
    input  word        merge_base,
    input  word        wdata,
    input  logic [1:0] addr_lo,
    input  mem_size_t  size,
    input  logic       is_unsigned,
    output word        load_value,
    output word        merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        ext_bit;

    always_comb begin
        byte_lane   = load_word[{addr_lo, 3'b000} +: 8];
        half_lane   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        ext_bit     = 1'b0;
        load_value  = load_word;
        merged_word = wdata;
        case (size)
            SIZE_B: begin
                ext_bit     = ~is_unsigned & byte_lane[7];
                load_value  = {{24{ext_bit}}, byte_lane};
                merged_word = merge_base;
                merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                ext_bit     = ~is_unsigned & half_lane[15];
                load_value  = {{16{ext_bit}}, half_lane};
                merged_word = merge_base;
                if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
                else            merged_word[15:0]  = wdata[15:0];
            end
            default: begin
                load_value  = load_word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side access unit: converts byte/half/word loads and stores into word-only
// data_memory traffic, faulting misaligned or out-of-range requests.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10,
    parameter int READ_LATENCY  = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [31:0]            req_address,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_fault,
    output data_memory_interface_t mem_sig,
    input  word                    mem_rdata
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

    lsu_state_t       state;
    lsu_state_t       next_state;
    logic [CNT_W-1:0] wait_cnt;
    word              addr_q;
    word              wdata_q;
    mem_size_t        size_q;
    logic             unsigned_q;
    word              rmw_word;
    word              resp_rdata_q;
    logic             resp_fault_q;
    word              load_value;
    word              merged_word;
    logic             accept;
    logic             req_fault;
    logic             wait_done;

    assign accept     = req_valid && (state == IDLE);
    assign req_fault  = is_misaligned(req_size, req_address[1:0])
                     || ((req_address >> MEM_ADDR_BITS) != 32'd0);
    assign wait_done  = (wait_cnt == CNT_LAST);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;

    lsu_lane_align u_lane_align (
        .load_word   (mem_rdata),
        .merge_base  (rmw_word),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault)                next_state = RESP;
                    else if (!req_write)          next_state = LD_REQ;
                    else if (req_size == SIZE_W)  next_state = ST_WR;
                    else                          next_state = RMW_REQ;
                end
            end
            LD_REQ:   next_state = LD_WAIT;
            LD_WAIT:  if (wait_done) next_state = RESP;
            ST_WR:    next_state = RESP;
            RMW_REQ:  next_state = RMW_WAIT;
            RMW_WAIT: if (wait_done) next_state = RMW_WR;
            RMW_WR:   next_state = RESP;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Memory is enabled only in the request and write states; everything else idles the port.
    always_comb begin
        mem_sig         = '0;
        mem_sig.mem_en  = MEM_READ_EN;
        mem_sig.address = {addr_q[31:2], 2'b00};
        case (state)
            LD_REQ, RMW_REQ: mem_sig.mem_enable = 1'b1;
            ST_WR: begin
                mem_sig.mem_enable = 1'b1;
                mem_sig.mem_en     = MEM_WRITE_EN;
                mem_sig.data_in    = wdata_q;
            end
            RMW_WR: begin
                mem_sig.mem_enable = 1'b1;
                mem_sig.mem_en     = MEM_WRITE_EN;
                mem_sig.data_in    = merged_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= SIZE_B;
            unsigned_q   <= 1'b0;
            rmw_word     <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q     <= req_address;
                wdata_q    <= req_wdata;
                size_q     <= mem_size_t'(req_size);
                unsigned_q <= req_unsigned;
            end
            if ((state == LD_WAIT) || (state == RMW_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            else                                           wait_cnt <= '0;
            if ((state == RMW_WAIT) && wait_done) rmw_word <= mem_rdata;
            // Response fields change only as RESP is entered, so they hold between responses.
            if ((next_state == RESP) && (state != RESP)) begin
                resp_rdata_q <= (state == LD_WAIT) ? load_value : '0;
                resp_fault_q <= (state == IDLE);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a READ_LATENCY=1 unit for function/latency
// and a READ_LATENCY=3 unit for back-to-back ordering.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] rdata;
    } load_vec_t;

    logic clock;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    logic                   req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]             req_size;
    logic [31:0]            req_address, req_wdata;
    logic                   resp_valid, resp_fault;
    logic [31:0]            resp_rdata;
    data_memory_interface_t mem_sig;
    word                    mem_rdata;

    logic                   req_valid2, req_ready2, req_write2, req_unsigned2;
    logic [1:0]             req_size2;
    logic [31:0]            req_address2, req_wdata2;
    logic                   resp_valid2, resp_fault2;
    logic [31:0]            resp_rdata2;
    data_memory_interface_t mem_sig2;
    word                    mem_rdata2;

    exp_t        sb[$];
    logic [31:0] sb2[$];

    word mem  [256];
    word mem2 [256];
    word pipe2 [3];
    int  wr_count;
    int  en_count;
    int  last_wr_cyc;

    load_store_unit #(.MEM_ADDR_BITS(10), .READ_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_sig(mem_sig), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MEM_ADDR_BITS(10), .READ_LATENCY(3)) dut_rl3 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_size(req_size2), .req_unsigned(req_unsigned2), .req_address(req_address2),
        .req_wdata(req_wdata2), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .resp_fault(resp_fault2), .mem_sig(mem_sig2), .mem_rdata(mem_rdata2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h0;
            mem2[i] = 32'h0;
        end
        mem2[16] = 32'hCAFEF00D;
        mem2[17] = 32'h01234567;
        for (int i = 0; i < 3; i++) pipe2[i] = 32'h0;
        mem_rdata   = 32'h0;
        wr_count    = 0;
        en_count    = 0;
        last_wr_cyc = -1;
    end

    // Word memory with one cycle of read latency, plus activity counters.
    always @(posedge clock) begin
        if (mem_sig.mem_enable) begin
            en_count <= en_count + 1;
            if (mem_sig.mem_en == MEM_WRITE_EN) begin
                mem[mem_sig.address[9:2]] <= mem_sig.data_in;
                wr_count    <= wr_count + 1;
                last_wr_cyc <= cyc;
            end else begin
                mem_rdata <= mem[mem_sig.address[9:2]];
            end
        end
    end

    // Read-only memory with three cycles of read latency.
    always @(posedge clock) begin
        pipe2[0] <= mem2[mem_sig2.address[9:2]];
        pipe2[1] <= pipe2[0];
        pipe2[2] <= pipe2[1];
    end
    assign mem_rdata2 = pipe2[2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_fault", 32'(resp_fault), 32'(e.fault));
                checkOutput("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && resp_valid2) begin
            if (sb2.size() == 0) begin
                checkOutput("rl3_unexpected_resp", 32'(resp_valid2), 32'd0);
            end else begin
                checkOutput("rl3_resp_rdata", resp_rdata2, sb2.pop_front());
                checkOutput("rl3_resp_fault", 32'(resp_fault2), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_fault,
                                 input int lat, input bit push, output int t);
        int waited;
        exp_t e;
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_address  = addr;
        req_wdata    = wdata;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) checkOutput("accept_timeout", 32'(req_ready), 32'd1);
        t = cyc;
        if (push) begin
            e.rdata = exp_rdata;
            e.fault = exp_fault;
            e.due   = t + lat;
            sb.push_back(e);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || sb2.size() != 0)
            checkOutput("drain_timeout", 32'(sb.size() + sb2.size()), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        load_vec_t loads[7];
        int t;
        int wr_before;
        int en_before;
        int low;

        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_address = 32'h0; req_wdata = 32'h0;
        req_valid2 = 1'b0; req_write2 = 1'b0; req_size2 = 2'd2; req_unsigned2 = 1'b0;
        req_address2 = 32'h0; req_wdata2 = 32'h0;

        repeat (3) @(negedge clock);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_fault", 32'(resp_fault), 32'd0);
        checkOutput("rst_mem_enable", 32'(mem_sig.mem_enable), 32'd0);
        reset_n = 1'b1;

        applyStimulus(1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, t);
        waitDrain();
        checkOutput("sw_write_cycle", 32'(last_wr_cyc), 32'(t + 1));
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, t);
        waitDrain();

        wr_before = wr_count;
        applyStimulus(1'b1, SIZE_B, 1'b0, 32'h11, 32'h000000A5, 32'h0, 1'b0, 4, 1'b1, t);
        waitDrain();
        checkOutput("sb_write_count", 32'(wr_count), 32'(wr_before + 1));
        checkOutput("sb_write_cycle", 32'(last_wr_cyc), 32'(t + 3));
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0, 3, 1'b1, t);

        loads[0] = '{SIZE_B, 1'b0, 32'h13, 32'hFFFFFFDE};
        loads[1] = '{SIZE_B, 1'b1, 32'h13, 32'h000000DE};
        loads[2] = '{SIZE_H, 1'b0, 32'h12, 32'hFFFFDEAD};
        loads[3] = '{SIZE_H, 1'b1, 32'h12, 32'h0000DEAD};
        loads[4] = '{SIZE_B, 1'b0, 32'h11, 32'hFFFFFFA5};
        loads[5] = '{SIZE_H, 1'b1, 32'h10, 32'h0000A5EF};
        loads[6] = '{SIZE_B, 1'b1, 32'h10, 32'h000000EF};
        foreach (loads[i])
            applyStimulus(1'b0, loads[i].size, loads[i].uns, loads[i].addr, 32'h0,
                          loads[i].rdata, 1'b0, 3, 1'b1, t);
        waitDrain();

        applyStimulus(1'b1, SIZE_H, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 4, 1'b1, t);
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 32'h1234A5EF, 1'b0, 3, 1'b1, t);
        waitDrain();

        en_before = en_count;
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h11,  32'h0, 32'h0, 1'b1, 1, 1'b1, t);
        applyStimulus(1'b1, SIZE_H, 1'b0, 32'h03,  32'h5555, 32'h0, 1'b1, 1, 1'b1, t);
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 1'b1, t);
        applyStimulus(1'b0, 2'd3,   1'b0, 32'h04,  32'h0, 32'h0, 1'b1, 1, 1'b1, t);
        waitDrain();
        checkOutput("fault_mem_enable", 32'(en_count), 32'(en_before));

        applyStimulus(1'b1, SIZE_W, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, t);
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 3, 1'b1, t);
        waitDrain();
        wr_before = wr_count;
        applyStimulus(1'b1, SIZE_B, 1'b0, 32'h20, 32'h000000FF, 32'h0, 1'b0, 4, 1'b0, t);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("abort_resp_rdata", resp_rdata, 32'd0);
        checkOutput("abort_resp_fault", 32'(resp_fault), 32'd0);
        checkOutput("abort_mem_enable", 32'(mem_sig.mem_enable), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("abort_write_count", 32'(wr_count), 32'(wr_before));
        applyStimulus(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 3, 1'b1, t);
        waitDrain();

        sb2.push_back(32'hCAFEF00D);
        sb2.push_back(32'h01234567);
        @(negedge clock);
        req_valid2   = 1'b1;
        req_address2 = 32'h40;
        checkOutput("rl3_ready_idle", 32'(req_ready2), 32'd1);
        @(posedge clock);
        #1 req_address2 = 32'h44;
        low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req_ready2) break;
            low++;
        end
        checkOutput("rl3_ready_low", 32'(low), 32'd5);
        @(posedge clock);
        #1 req_valid2 = 1'b0;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
